// File: rtl/axis_pkt_commit_fifo_if.sv
// axis_pkt_commit_fifo_if: AXI-Stream bundle used on both sides of the packet FIFO
interface AXIS_int #(
    parameter int DATA_BYTES = 4
) (
    input logic clk
);
    logic [8*DATA_BYTES-1:0] tdata;
    logic [DATA_BYTES-1:0]   tkeep;
    logic [DATA_BYTES-1:0]   tstrb;
    logic                    tvalid;
    logic                    tready;
    logic                    tlast;
    logic [7:0]              tid;
    logic [7:0]              tdest;
    logic                    tuser;

    modport Master (input clk, output tdata, tkeep, tstrb, tvalid, tlast, tid, tdest, tuser, input tready);
    modport Slave  (input clk, input tdata, tkeep, tstrb, tvalid, tlast, tid, tdest, tuser, output tready);
endinterface

// File: rtl/axis_pkt_commit_fifo.sv
// axis_pkt_commit_fifo: store-and-forward AXIS FIFO that only releases whole, good packets
module axis_pkt_commit_fifo #(
    parameter int DEPTH          = 64,
    parameter int MAX_PKT_WORDS  = DEPTH,
    parameter int DROP_CNT_WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      aresetn,
    AXIS_int.Slave                    axis_in,
    AXIS_int.Master                   axis_out,
    input  logic                      in_bad,
    output logic                      pkt_dropped,
    output logic [DROP_CNT_WIDTH-1:0] drop_count
);
    localparam int DB = $bits(axis_in.tkeep);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int W  = 8*DB + DB + 1;

    if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("DEPTH must be a power of two >= 4");
    end
    if (MAX_PKT_WORDS < 1 || MAX_PKT_WORDS > DEPTH) begin : g_bad_max
        $error("MAX_PKT_WORDS must be in 1..DEPTH");
    end
    if ($bits(axis_out.tkeep) != DB) begin : g_bad_width
        $error("axis_in and axis_out DATA_BYTES differ");
    end

    typedef enum logic [1:0] {WR_IDLE, WR_PKT, WR_DISCARD} wr_state_e;

    (* ram_style = "distributed" *) logic [W-1:0] mem_q [DEPTH];

    wr_state_e               state_q;
    logic [PW-1:0]           wr_ptr_q, wr_commit_q, rd_ptr_q, pkt_len_q;
    logic                    pkt_dropped_q;
    logic [DROP_CNT_WIDTH-1:0] drop_count_q;
    logic                    tvalid_q, tlast_q;
    logic [8*DB-1:0]         tdata_q;
    logic [DB-1:0]           tkeep_q;

    logic [PW-1:0] used;
    logic          beat, full, bad, wr_en, drop_ev, empty, load;
    logic          unused_ok;

    assign used    = wr_ptr_q - rd_ptr_q;
    assign full    = used == PW'(DEPTH);
    assign beat    = axis_in.tvalid;
    assign bad     = in_bad || full || pkt_len_q == PW'(MAX_PKT_WORDS);
    assign wr_en   = beat && state_q != WR_DISCARD && !bad;
    assign drop_ev = beat && axis_in.tlast && (state_q == WR_DISCARD || bad);
    assign empty   = rd_ptr_q == wr_commit_q;
    assign load    = !empty && (!tvalid_q || axis_out.tready);

    // Good beats land in RAM; commit bookkeeping decides whether the reader ever sees them
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= {axis_in.tdata, axis_in.tkeep, axis_in.tlast};
    end

    // Write FSM: advance on good beats, commit on tlast, rewind and count on bad packets
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q       <= WR_IDLE;
            wr_ptr_q      <= '0;
            wr_commit_q   <= '0;
            pkt_len_q     <= '0;
            pkt_dropped_q <= 1'b0;
            drop_count_q  <= '0;
        end else begin
            pkt_dropped_q <= drop_ev;
            if (drop_ev && !(&drop_count_q)) drop_count_q <= drop_count_q + DROP_CNT_WIDTH'(1);
            if (beat) begin
                case (state_q)
                    WR_IDLE, WR_PKT: begin
                        if (bad) begin
                            wr_ptr_q  <= wr_commit_q;
                            pkt_len_q <= '0;
                            state_q   <= axis_in.tlast ? WR_IDLE : WR_DISCARD;
                        end else if (axis_in.tlast) begin
                            wr_ptr_q    <= wr_ptr_q + PW'(1);
                            wr_commit_q <= wr_ptr_q + PW'(1);
                            pkt_len_q   <= '0;
                            state_q     <= WR_IDLE;
                        end else begin
                            wr_ptr_q  <= wr_ptr_q + PW'(1);
                            pkt_len_q <= pkt_len_q + PW'(1);
                            state_q   <= WR_PKT;
                        end
                    end
                    WR_DISCARD: if (axis_in.tlast) state_q <= WR_IDLE;
                    default:    state_q <= WR_IDLE;
                endcase
            end
        end
    end

    // Output register control: fetch the next committed word whenever the slot is free
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            rd_ptr_q <= '0;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
        end else if (load) begin
            rd_ptr_q <= rd_ptr_q + PW'(1);
            tvalid_q <= 1'b1;
            tlast_q  <= mem_q[rd_ptr_q[AW-1:0]][0];
        end else if (axis_out.tready) begin
            tvalid_q <= 1'b0;
        end
    end

    // Payload half of the output register; its reset value does not matter
    always_ff @(posedge clk) begin
        if (load) {tdata_q, tkeep_q} <= mem_q[rd_ptr_q[AW-1:0]][W-1:1];
    end

    assign axis_in.tready  = 1'b1;
    assign axis_out.tvalid = tvalid_q;
    assign axis_out.tdata  = tdata_q;
    assign axis_out.tkeep  = tkeep_q;
    assign axis_out.tlast  = tlast_q;
    assign axis_out.tstrb  = '1;
    assign axis_out.tid    = '0;
    assign axis_out.tdest  = '0;
    assign axis_out.tuser  = 1'b0;
    assign pkt_dropped     = pkt_dropped_q;
    assign drop_count      = drop_count_q;
    assign unused_ok       = ^{axis_in.clk, axis_out.clk, axis_in.tid, axis_in.tdest, axis_in.tuser, axis_in.tstrb};
endmodule
